// File: rtl/wb_mailbox.sv
// Wishbone B4 mailbox: a CPU-facing register window over two 32-bit FIFOs,
// RX (stream in -> CPU) and TX (CPU -> stream out), with a level interrupt.
module wb_mailbox #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    input  logic        out_ready_i,
    output logic        irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_IRQEN  = 2'd2;

    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   tx_mem_q [DEPTH];

    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [3:0]    irq_en_q, irq_en_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   dat_q, dat_d;

    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push, rx_pop, tx_push, tx_pop;
    logic          req;
    logic [31:0]   status;
    logic          unused_inputs;

    function automatic logic [31:0] pack_status(
        input logic [CW-1:0] rx_cnt,
        input logic [CW-1:0] tx_cnt,
        input logic          rx_f,
        input logic          rx_e,
        input logic          tx_f,
        input logic          tx_e
    );
        return {8'h00, 8'(tx_cnt), 8'(rx_cnt), 4'h0, tx_f, tx_e, rx_f, !rx_e};
    endfunction

    // Flags come from registered counts only, so a pop never frees a slot
    // for a push in the same cycle.
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);

    assign status = pack_status(rx_cnt_q, tx_cnt_q, rx_full, rx_empty, tx_full, tx_empty);
    assign irq_o  = |(status[3:0] & irq_en_q);

    assign in_ready_o  = !rx_full;
    assign rx_push     = in_valid_i & in_ready_o;
    assign out_valid_o = !tx_empty;
    assign out_data_o  = tx_mem_q[tx_rptr_q];
    assign tx_pop      = out_valid_o & out_ready_i;

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign wb_rty_o = 1'b0;

    // Burst signalling and the unused address bits carry no meaning here.
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:4], wb_adr_i[1:0]};

    // The pending termination blocks resampling, giving two cycles per beat.
    assign req = wb_cyc_i & wb_stb_i & !ack_q & !err_q;

    always_comb begin
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        irq_en_d = irq_en_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        if (req) begin
            case (wb_adr_i[3:2])
                ADR_DATA: begin
                    if (wb_we_i) begin
                        if ((wb_sel_i == 4'hF) && !tx_full) begin
                            tx_push = 1'b1;
                            ack_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (!rx_empty) begin
                        rx_pop = 1'b1;
                        ack_d  = 1'b1;
                        dat_d  = rx_mem_q[rx_rptr_q];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ADR_STATUS: begin
                    ack_d = 1'b1;
                    if (!wb_we_i) dat_d = status;
                end
                ADR_IRQEN: begin
                    ack_d = 1'b1;
                    if (wb_we_i) irq_en_d = wb_dat_i[3:0];
                    else         dat_d    = {28'h0, irq_en_q};
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        rx_wptr_d = rx_push ? rx_wptr_q + PW'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + PW'(1) : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_wptr_d = tx_push ? tx_wptr_q + PW'(1) : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + PW'(1) : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            irq_en_q  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            irq_en_q  <= irq_en_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= in_data_i;
        if (tx_push) tx_mem_q[tx_wptr_q] <= wb_dat_i;
    end

endmodule

// File: doc/wb_mailbox.md
WB_MAILBOX -- requirements
Module: wb_mailbox

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of each FIFO's depth (valid range 1..7).
REQ-002 SHALL have ports, clock and reset first:
- wb_clk_i  in  1  sole clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  byte address; only [3:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type; ignored.
- wb_bte_i  in  2  burst type; ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry; tied 0.
- in_valid_i  in  1  inbound word valid.
- in_data_i  in  32  inbound word.
- in_ready_o  out  1  RX FIFO can accept.
- out_valid_o  out  1  TX FIFO head valid.
- out_data_o  out  32  TX FIFO head word.
- out_ready_i  in  1  consumer accepts head.
- irq_o  out  1  level interrupt to the OR1200 PIC.

Function
REQ-003 SHALL contain two 2^DEPTH_LOG2 x 32 FIFOs: RX (stream in -> CPU) and TX (CPU -> stream out).
REQ-004 Each FIFO SHALL keep read/write pointers wrapping modulo 2^DEPTH_LOG2 and a count DEPTH_LOG2+1 bits wide; full means count == 2^DEPTH_LOG2.
REQ-005 A registered request SHALL be sampled when wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o.
REQ-006 On the edge that samples a request, the side effect SHALL occur and exactly one of wb_ack_o/wb_err_o SHALL be set high for one cycle: 1-cycle latency, minimum 2 cycles per beat.
REQ-007 Bursts (any cti/bte) SHALL be handled as successive classic beats.
REQ-008 Register map by adr[3:2]:
- 0 DATA: write pushes wb_dat_i to TX; read pops RX and returns its head.
- 1 STATUS (read-only): [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [15:8] rx_count, [23:16] tx_count, other bits 0.
- 2 IRQ_EN: bits [3:0] read/write, other bits read 0.
- 3: err, no effect.
REQ-009 STATUS writes SHALL be acked and ignored.
REQ-010 A DATA write with wb_sel_i != 4'hF SHALL err with no push.
REQ-011 A DATA write when TX is full SHALL err with no push.
REQ-012 A DATA read when RX is empty SHALL err, return 0, and not pop.
REQ-013 wb_dat_o SHALL be registered with the ack, and SHALL be 0 on writes and errors.
REQ-014 in_ready_o SHALL equal !rx_full; a push SHALL occur on in_valid_i & in_ready_o.
REQ-015 out_valid_o SHALL equal !tx_empty and out_data_o SHALL equal the TX head; a pop SHALL occur on out_valid_o & out_ready_i.
REQ-016 Simultaneous push and pop on one FIFO in the same cycle SHALL both occur with the count unchanged. When the FIFO is full, ready/full flags derive from the registered count, so a same-cycle pop does not enable a push.
REQ-017 irq_o SHALL equal |(STATUS[3:0] & IRQ_EN[3:0]), computed from registered state only.
REQ-018 If wb_cyc_i drops in the cycle after sampling, the already-performed side effect SHALL stand and the ack/err pulse SHALL still be driven.

Reset
REQ-019 While wb_rst_ni is low, the block SHALL asynchronously clear pointers, counts and IRQ_EN, and drive wb_ack_o=0, wb_err_o=0, wb_dat_o=0, out_valid_o=0, in_ready_o=1, irq_o=0.
REQ-020 A transaction in flight at reset SHALL receive no termination; FIFO contents SHALL be treated as discarded.
REQ-021 After wb_rst_ni rises, the first request SHALL be sampled on the next rising edge.

Verification
REQ-022 Push 0xA5A5_0001 via stream, then CPU reads adr 0x0 -> ack one cycle later with wb_dat_o=0xA5A5_0001; STATUS then reads 0x0000_0004.
REQ-023 CPU writes 16 words (sel=F) with out_ready_i=0 (DEPTH_LOG2=4) -> 16 acks; 17th write errs; STATUS=0x0010_0008. Then raise out_ready_i -> 16 words emerge in order, out_valid_o falls.
REQ-024 Read DATA with RX empty -> wb_err_o pulse, wb_dat_o=0, counts unchanged. Write adr 0xC -> err. DATA write with sel=4'h3 -> err, tx_count unchanged.
REQ-025 Set IRQ_EN=0x1, stream-push one word -> irq_o rises the cycle after the push; CPU pops -> irq_o falls the cycle after the ack.
REQ-026 Fill RX (16 words), then in the same cycle pop via CPU and present in_valid_i=1 -> no push that cycle (in_ready_o=0), rx_count=15; push next cycle -> rx_count=16.
REQ-027 Assert wb_rst_ni low mid-burst with 3 words in each FIFO -> outputs take reset values immediately (before next edge); STATUS after release reads 0x0000_0004.
